// File: rtl/rotator_arbiter.sv
// Two-requester round-robin arbiter sharing one staged rotator and a 1-entry output register.
// Optional RA_STATS_EN adds saturating per-requester transfer counters.
module rotator_arbiter #(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  logic [WIDTH-1:0]       req0_data,
  input  logic [SHIFT_WIDTH-1:0] req0_amount,
  input  logic                   req0_dir,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  logic [WIDTH-1:0]       req1_data,
  input  logic [SHIFT_WIDTH-1:0] req1_amount,
  input  logic                   req1_dir,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_id
`ifdef RA_STATS_EN
  ,
  output logic [15:0]            stat_cnt0,
  output logic [15:0]            stat_cnt1
`endif
);

  logic                   r_valid;
  logic [WIDTH-1:0]       r_data;
  logic                   r_id;
  logic                   r_last;

  logic                   w_free;
  logic                   w_g0;
  logic                   w_g1;
  logic                   w_xfer;
  logic [WIDTH-1:0]       w_data;
  logic [SHIFT_WIDTH-1:0] w_amt;
  logic                   w_dir;
  logic [SHIFT_WIDTH-1:0] w_lamt;
  logic [WIDTH-1:0]       w_stage [0:SHIFT_WIDTH];

  assign w_free = !r_valid || out_ready;
  assign w_g0   = !rst && w_free && req0_valid && (!req1_valid || r_last);
  assign w_g1   = !rst && w_free && req1_valid && (!req0_valid || !r_last);
  assign w_xfer = w_g0 || w_g1;

  assign req0_ready = w_g0;
  assign req1_ready = w_g1;

  assign w_data = w_g1 ? req1_data   : req0_data;
  assign w_amt  = w_g1 ? req1_amount : req0_amount;
  assign w_dir  = w_g1 ? req1_dir    : req0_dir;

  // right rotate by n equals left rotate by (WIDTH - n) mod WIDTH
  assign w_lamt = w_dir ? w_amt : (~w_amt + 1'b1);

  assign w_stage[0] = w_data;

  for (genvar s = 0; s < SHIFT_WIDTH; s++) begin : g_rot
    localparam int K = 1 << s;
    logic [WIDTH-1:0] w_rot;
    assign w_rot = {w_stage[s][WIDTH-1-K:0],
                    w_stage[s][WIDTH-1:WIDTH-K]};
    assign w_stage[s+1] = w_lamt[s] ? w_rot : w_stage[s];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_id    <= 1'b0;
      r_last  <= 1'b1;
    end else if (w_xfer) begin
      r_valid <= 1'b1;
      r_data  <= w_stage[SHIFT_WIDTH];
      r_id    <= w_g1;
      r_last  <= w_g1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_id    = r_id;

`ifdef RA_STATS_EN
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_g0 && r_cnt0 != 16'hFFFF) r_cnt0 <= r_cnt0 + 16'd1;
      if (w_g1 && r_cnt1 != 16'hFFFF) r_cnt1 <= r_cnt1 + 16'd1;
    end
  end

  assign stat_cnt0 = r_cnt0;
  assign stat_cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_rotator_arbiter.sv
// Randomized bench for rotator_arbiter against a transaction-level model,
// plus directed cases with literal expectations.
module tb_rotator_arbiter;

  localparam int W  = 8;
  localparam int SW = 3;

  logic          clk;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [W-1:0]  req0_data, req1_data;
  logic [SW-1:0] req0_amount, req1_amount;
  logic          req0_dir, req1_dir;
  logic          out_valid, out_ready, out_id;
  logic [W-1:0]  out_data;
`ifdef RA_STATS_EN
  logic [15:0]   stat_cnt0, stat_cnt1;
`endif

  rotator_arbiter #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_data(req0_data), .req0_amount(req0_amount),
    .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_data(req1_data), .req1_amount(req1_amount),
    .req1_dir(req1_dir),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
`ifdef RA_STATS_EN
    , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // model state
  bit          m_valid;
  bit [W-1:0]  m_data;
  bit          m_id;
  int          m_last;
  int          m_cnt0, m_cnt1;

  function automatic bit [W-1:0] rot(input bit [W-1:0] d,
                                     input int a, input bit left);
    bit [2*W-1:0] x;
    int n;
    n = a % W;
    if (n == 0) return d;
    x = {{W{1'b0}}, d};
    if (left) x = (x << n) | (x >> (W - n));
    else      x = (x >> n) | (x << (W - n));
    return x[W-1:0];
  endfunction

  task automatic chk(input string name, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp,
               $time);
    end
  endtask

  // one clock: drive, check against model, advance model at the edge
  task automatic step(input bit r, input bit v0, input bit [W-1:0] d0,
                      input bit [SW-1:0] a0, input bit dr0,
                      input bit v1, input bit [W-1:0] d1,
                      input bit [SW-1:0] a1, input bit dr1,
                      input bit ordy);
    bit free, g0, g1;
    @(negedge clk);
    rst = r;
    req0_valid = v0; req0_data = d0; req0_amount = a0; req0_dir = dr0;
    req1_valid = v1; req1_data = d1; req1_amount = a1; req1_dir = dr1;
    out_ready = ordy;
    #1;
    free = !m_valid || ordy;
    g0 = !r && free && v0 && (!v1 || m_last == 1);
    g1 = !r && free && v1 && (!v0 || m_last == 0);
    chk("req0_ready", req0_ready, g0);
    chk("req1_ready", req1_ready, g1);
    chk("out_valid", out_valid, m_valid);
    chk("out_data", out_data, m_data);
    chk("out_id", out_id, m_id);
`ifdef RA_STATS_EN
    chk("stat_cnt0", stat_cnt0, m_cnt0);
    chk("stat_cnt1", stat_cnt1, m_cnt1);
`endif
    @(posedge clk);
    if (r) begin
      m_valid = 0; m_data = 0; m_id = 0; m_last = 1;
      m_cnt0 = 0; m_cnt1 = 0;
    end else if (g0 || g1) begin
      m_valid = 1;
      m_id = g1;
      m_last = g1 ? 1 : 0;
      m_data = g1 ? rot(d1, a1, dr1) : rot(d0, a0, dr0);
      if (g0 && m_cnt0 < 16'hFFFF) m_cnt0++;
      if (g1 && m_cnt1 < 16'hFFFF) m_cnt1++;
    end else if (m_valid && ordy) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic idle(input bit r, input bit ordy);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  task automatic both(input bit ordy);
    step(0, 1, W'($urandom), SW'($urandom), 1'($urandom),
            1, W'($urandom), SW'($urandom), 1'($urandom), ordy);
  endtask

  logic [W-1:0] held_d;
  logic         held_i;

  initial begin
    rst = 1; out_ready = 0;
    req0_valid = 0; req1_valid = 0;
    req0_data = 0; req1_data = 0;
    req0_amount = 0; req1_amount = 0;
    req0_dir = 0; req1_dir = 0;
    m_valid = 0; m_data = 0; m_id = 0; m_last = 1;
    m_cnt0 = 0; m_cnt1 = 0;

    idle(1, 0);
    idle(1, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);

    // single left rotate
    step(0, 1, 8'b1000_0001, 1, 1, 0, 0, 0, 0, 1);
    chk("lrot_valid", out_valid, 1);
    chk("lrot_data", out_data, 8'b0000_0011);
    chk("lrot_id", out_id, 0);

    // right rotate and passthrough
    step(0, 0, 0, 0, 0, 1, 8'hB4, 3, 0, 1);
    chk("rrot_data", out_data, 8'h96);
    chk("rrot_id", out_id, 1);
    step(0, 0, 0, 0, 0, 1, 8'hA5, 0, 0, 1);
    chk("pass_data", out_data, 8'hA5);

    // fairness right after reset
    idle(1, 1);
    for (int i = 0; i < 6; i++) begin
      both(1);
      chk("fair_id", out_id, i % 2);
      chk("fair_valid", out_valid, 1);
    end

    // backpressure
    for (int i = 0; i < 4; i++) begin
      both(0);
      if (i == 0) begin
        held_d = out_data;
        held_i = out_id;
      end
      chk("bp_data", out_data, held_d);
      chk("bp_id", out_id, held_i);
    end
    both(1);
    chk("bp_release_valid", out_valid, 1);
    chk("bp_release_id", out_id, !held_i);

    // reset while holding a result
    both(0);
    chk("pre_rst_valid", out_valid, 1);
    idle(1, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    both(1);
    chk("post_rst_id", out_id, 0);

`ifdef RA_STATS_EN
    idle(1, 1);
    for (int i = 0; i < 5; i++)
      step(0, 1, 8'h11, 1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step(0, 0, 0, 0, 0, 1, 8'h22, 2, 0, 1);
    chk("stat0_lit", stat_cnt0, 5);
    chk("stat1_lit", stat_cnt1, 3);
    @(negedge clk);
    force dut.r_cnt0 = 16'hFFFF;
    @(negedge clk);
    release dut.r_cnt0;
    m_cnt0 = 16'hFFFF;
    idle(0, 1);
    step(0, 1, 8'h11, 1, 1, 0, 0, 0, 0, 1);
    chk("stat0_sat", stat_cnt0, 16'hFFFF);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0),
           1'($urandom), W'($urandom), SW'($urandom), 1'($urandom),
           1'($urandom), W'($urandom), SW'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rotator_arbiter.md
Name: rotator_arbiter

Overview:
Shares one WIDTH-bit rotate datapath (left/right, power-of-two staged rotate) between two requesters. Arbitration is round-robin with valid/ready handshakes on each input. The result is held in a single-entry registered output stage tagged with the winning requester's id. The block sits between two client pipelines and a downstream consumer. It sustains one rotate per cycle when the consumer is ready.

Parameters:
WIDTH, 8, data width in bits; must be a power of two, at least 2
SHIFT_WIDTH, 3, width of the rotate amount; equals log2(WIDTH)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_data  input  WIDTH  requester 0 operand
req0_amount  input  SHIFT_WIDTH  requester 0 rotate amount
req0_dir  input  1  requester 0 direction: 1 = rotate left, 0 = rotate right
req1_valid, req1_ready, req1_data, req1_amount, req1_dir  same widths and meaning for requester 1
out_valid  output  1  result register holds a valid result
out_ready  input  1  consumer accepts the result
out_data  output  WIDTH  rotated result
out_id  output  1  requester that produced out_data (0 or 1)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_id=0, last_grant=1. With last_grant=1, requester 0 wins the first contest.
- Ready outputs are combinational. req0_ready and req1_ready are both 0 while rst=1.
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Slot availability: slot_free = !out_valid || out_ready.
- Grant:
  - Only one valid requester: it is granted if slot_free.
  - Both valid: the requester other than last_grant is granted.
  - At most one reqN_ready is high, and only when slot_free and reqN_valid are both high.
- Transfer: a transfer occurs when reqN_valid && reqN_ready. On that clock edge:
  - out_data <= rotate(reqN_data, reqN_amount, reqN_dir)
  - out_id <= N
  - out_valid <= 1
  - last_grant <= N
- Drain: if out_valid && out_ready with no new transfer, out_valid <= 0. out_data and out_id keep their last values.
- Simultaneous drain and accept in the same cycle: the register is overwritten with the new result and out_valid stays 1. This gives full throughput.
- Latency: exactly 1 cycle from an accepted request to out_valid.
- Backpressure: while out_valid=1 and out_ready=0:
  - out_data and out_id stay stable.
  - Both readys are 0.
  - last_grant is unchanged.
- Rotate arithmetic:
  - Amount is taken modulo WIDTH, which is implicit from the SHIFT_WIDTH width.
  - Amount 0 passes the operand through unchanged.
  - Bits shifted out of one end re-enter at the other end; no bits are lost.
  - Implementation is a SHIFT_WIDTH-stage combinational rotator in front of the output register.
- last_grant updates only on a transfer. Idle cycles do not disturb fairness.
- Reset mid-operation: a pending result is discarded; out_valid=0 on the cycle after rst is sampled high.
- Requester inputs are not required to stay stable while reqN_ready=0. Only the values present on the transfer cycle matter.

Optional Feature:
Macro RA_STATS_EN.
- Defined: adds output ports stat_cnt0 and stat_cnt1, 16 bits each.
  - Each counter increments on a transfer from the matching requester.
  - Counters saturate at 16'hFFFF and never wrap.
  - Both reset to 0 on rst.
- Not defined: no ports, no counter logic; behaviour is otherwise identical.

Test Plan:
- Single left rotate: req0 data=8'b1000_0001, amount=1, dir=1, out_ready=1 -> next cycle out_valid=1, out_data=8'b0000_0011, out_id=0.
- Right rotate and passthrough: req1 data=8'hB4, amount=3, dir=0 -> out_data=8'h96, out_id=1. Then req1 data=8'hA5, amount=0 -> out_data=8'hA5.
- Contention fairness: both valid for 6 cycles with out_ready=1 held, first contest right after reset -> out_id sequence 0,1,0,1,0,1 on consecutive cycles; exactly one ready high per cycle.
- Backpressure: result held while out_ready=0 for 4 cycles with both requesters valid -> out_data/out_id stable, req0_ready=req1_ready=0. When out_ready rises, the same cycle accepts the next request (no bubble).
- Reset mid-operation: rst=1 for one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0. The next contest is won by requester 0.
- Under RA_STATS_EN, run 5 grants to req0 and 3 to req1 -> stat_cnt0=5, stat_cnt1=3. Force stat_cnt0 to 16'hFFFF, then grant req0 once more -> stat_cnt0 stays 16'hFFFF.
